// File: rtl/dm_responder_if.sv
// dm_responder_if
//   Load/store request/response bundle between a CPU M stage (master) and
//   the data-memory responder (slave).
//   req_valid/req_ready : request handshake, transfer on a clock edge with both high
//   req_we              : 1 = store, 0 = load
//   req_type            : 000 word, 001 half signed, 010 half unsigned,
//                         011 byte signed, 100 byte unsigned
//   req_addr/req_wdata  : byte address and store data
//   rsp_valid           : one-cycle response pulse qualifying rsp_rdata/rsp_err
//   rsp_rdata/rsp_err   : extended load data (0 for stores/errors), reject flag
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_type, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_type, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_responder.sv
// dm_responder
//   Memory-side end of the CPU load/store interface. Accepts one request at a
//   time, waits WAIT_CYCLES cycles, then commits (store writes memory / load
//   registers its result) on the edge entering RESP and pulses rsp_valid for
//   one cycle. Misaligned, out-of-range and illegal-type requests are rejected
//   with rsp_err=1, rsp_rdata=0 and no memory change, using normal timing.
// Ports
//   clk   : clock, rising edge
//   reset : asynchronous reset, active high; clears state and all memory words
//   bus   : dm_responder_if slave modport (request handshake + response)
// Parameters
//   ADDR_WORDS  : memory depth in 32-bit words (power of two, >= 2)
//   BASE_ADDR   : byte address of word 0 (word aligned)
//   WAIT_CYCLES : wait states between accept and response (0..15)
module dm_responder #(
  parameter int unsigned ADDR_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic           clk,
  input logic           reset,
  dm_responder_if.slave bus
);

  localparam int unsigned IDX_W    = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;
  localparam logic [32:0] SPAN     = 33'(ADDR_WORDS) << 2;
  localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0]  CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  localparam logic [2:0] T_WORD   = 3'b000;
  localparam logic [2:0] T_HALF_S = 3'b001;
  localparam logic [2:0] T_HALF_U = 3'b010;
  localparam logic [2:0] T_BYTE_S = 3'b011;
  localparam logic [2:0] T_BYTE_U = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [2:0]  lat_type;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem [ADDR_WORDS];

  // Request being worked on. With zero wait states the accept edge is also
  // the commit edge, so the live bus fields must be used while in IDLE.
  logic        cur_we;
  logic [2:0]  cur_type;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;

  logic [31:0]      offset;
  logic             in_range;
  logic             align_ok;
  logic             type_ok;
  logic             req_err;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic [31:0]      rd_word;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      load_val;
  logic [31:0]      wmask;
  logic [31:0]      wdata_al;
  logic             commit;
  logic             do_write;

  always_comb begin
    if (state == S_IDLE) begin
      cur_we    = bus.req_we;
      cur_type  = bus.req_type;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
    end else begin
      cur_we    = lat_we;
      cur_type  = lat_type;
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
    end
  end

  always_comb begin
    offset   = cur_addr - BASE_ADDR;
    in_range = (cur_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    type_ok  = (cur_type <= T_BYTE_U);
    lane     = offset[1:0];
    idx      = offset[IDX_W+1:2];
    unique case (cur_type)
      T_WORD:             align_ok = (lane == 2'b00);
      T_HALF_S, T_HALF_U: align_ok = (lane[0] == 1'b0);
      default:            align_ok = 1'b1;
    endcase
    req_err = !(in_range && type_ok && align_ok);
  end

  assign rd_word = mem[idx];

  always_comb begin
    unique case (lane)
      2'd0:    byte_v = rd_word[7:0];
      2'd1:    byte_v = rd_word[15:8];
      2'd2:    byte_v = rd_word[23:16];
      default: byte_v = rd_word[31:24];
    endcase
    half_v = lane[1] ? rd_word[31:16] : rd_word[15:0];

    unique case (cur_type)
      T_WORD:   load_val = rd_word;
      T_HALF_S: load_val = {{16{half_v[15]}}, half_v};
      T_HALF_U: load_val = {16'h0000, half_v};
      T_BYTE_S: load_val = {{24{byte_v[7]}}, byte_v};
      T_BYTE_U: load_val = {24'h000000, byte_v};
      default:  load_val = 32'h0000_0000;
    endcase
  end

  // Store data is replicated across all lanes so the mask alone picks the
  // bytes that change.
  always_comb begin
    unique case (cur_type)
      T_WORD: begin
        wmask    = 32'hFFFF_FFFF;
        wdata_al = cur_wdata;
      end
      T_HALF_S, T_HALF_U: begin
        wmask    = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wdata_al = {2{cur_wdata[15:0]}};
      end
      T_BYTE_S, T_BYTE_U: begin
        wmask    = 32'h0000_00FF << {lane, 3'b000};
        wdata_al = {4{cur_wdata[7:0]}};
      end
      default: begin
        wmask    = 32'h0000_0000;
        wdata_al = 32'h0000_0000;
      end
    endcase
  end

  assign commit   = (NO_WAIT && (state == S_IDLE) && bus.req_valid) ||
                    ((state == S_WAIT) && (cnt == 4'd0));
  assign do_write = commit && cur_we && !req_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      lat_we      <= 1'b0;
      lat_type    <= 3'b000;
      lat_addr    <= 32'h0000_0000;
      lat_wdata   <= 32'h0000_0000;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (commit) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= req_err;
        rsp_rdata_q <= (req_err || cur_we) ? 32'h0000_0000 : load_val;
      end

      unique case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            lat_we    <= bus.req_we;
            lat_type  <= bus.req_type;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            ready_q   <= 1'b0;
            if (NO_WAIT) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(ADDR_WORDS); i++) begin
        mem[i] <= 32'h0000_0000;
      end
    end else if (do_write) begin
      mem[idx] <= (rd_word & ~wmask) | (wdata_al & wmask);
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder
//   Three responders with different base/depth/wait settings run against a
//   byte-addressed reference memory and a cycle-count timing model. Every
//   falling edge compares ready/valid/rdata/err of each instance with the
//   model; directed requests also pin results to literal values.
module tb_dm_responder;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [NI-1:0]       rst_d;
  logic [NI-1:0]       rv;
  logic [NI-1:0]       we_d;
  logic [NI-1:0][2:0]  ty_d;
  logic [NI-1:0][31:0] ad_d;
  logic [NI-1:0][31:0] wd_d;

  dm_responder_if b0();
  dm_responder_if b1();
  dm_responder_if b2();

  assign b0.req_valid = rv[0];
  assign b0.req_we    = we_d[0];
  assign b0.req_type  = ty_d[0];
  assign b0.req_addr  = ad_d[0];
  assign b0.req_wdata = wd_d[0];
  assign b1.req_valid = rv[1];
  assign b1.req_we    = we_d[1];
  assign b1.req_type  = ty_d[1];
  assign b1.req_addr  = ad_d[1];
  assign b1.req_wdata = wd_d[1];
  assign b2.req_valid = rv[2];
  assign b2.req_we    = we_d[2];
  assign b2.req_type  = ty_d[2];
  assign b2.req_addr  = ad_d[2];
  assign b2.req_wdata = wd_d[2];

  logic [NI-1:0]       dut_rdy;
  logic [NI-1:0]       dut_vld;
  logic [NI-1:0]       dut_err;
  logic [NI-1:0][31:0] dut_rd;
  assign dut_rdy = {b2.req_ready, b1.req_ready, b0.req_ready};
  assign dut_vld = {b2.rsp_valid, b1.rsp_valid, b0.rsp_valid};
  assign dut_err = {b2.rsp_err, b1.rsp_err, b0.rsp_err};
  assign dut_rd  = {b2.rsp_rdata, b1.rsp_rdata, b0.rsp_rdata};

  dm_responder #(.ADDR_WORDS(64), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(1))
    u0 (.clk(clk), .reset(rst_d[0]), .bus(b0));
  dm_responder #(.ADDR_WORDS(32), .BASE_ADDR(32'h0000_0100), .WAIT_CYCLES(0))
    u1 (.clk(clk), .reset(rst_d[1]), .bus(b1));
  dm_responder #(.ADDR_WORDS(16), .BASE_ADDR(32'h0000_0040), .WAIT_CYCLES(3))
    u2 (.clk(clk), .reset(rst_d[2]), .bus(b2));

  function automatic logic [31:0] base_of(int k);
    case (k)
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0100;
      default: return 32'h0000_0040;
    endcase
  endfunction

  function automatic int words_of(int k);
    case (k)
      0:       return 64;
      1:       return 32;
      default: return 16;
    endcase
  endfunction

  function automatic int wait_of(int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  // ---------------- reference model ----------------
  logic [7:0]  mb [NI][256];
  bit          m_ready [NI];
  bit          m_busy  [NI];
  bit          m_resp  [NI];
  bit          m_valid [NI];
  logic        m_err   [NI];
  logic [31:0] m_rdata [NI];
  int          m_left  [NI];
  int          acc_cnt [NI];
  int          rsp_cnt [NI];
  logic        p_we [NI];
  logic [2:0]  p_ty [NI];
  logic [31:0] p_ad [NI];
  logic [31:0] p_wd [NI];

  task automatic model_reset(input int k);
    m_ready[k] = 1'b1;
    m_busy[k]  = 1'b0;
    m_resp[k]  = 1'b0;
    m_valid[k] = 1'b0;
    m_err[k]   = 1'b0;
    m_rdata[k] = 32'h0;
    m_left[k]  = 0;
    for (int i = 0; i < 256; i++) mb[k][i] = 8'h00;
  endtask

  task automatic predict(input int k, input logic we, input logic [2:0] ty,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic err, output logic [31:0] rdata);
    longint o;
    int size;
    logic [31:0] v;
    o = longint'(addr) - longint'(base_of(k));
    if (ty == 3'd0) size = 4;
    else if (ty == 3'd1 || ty == 3'd2) size = 2;
    else if (ty == 3'd3 || ty == 3'd4) size = 1;
    else size = 0;
    if (size == 0) err = 1'b1;
    else if (o < 0 || o >= 4 * words_of(k)) err = 1'b1;
    else if ((o % size) != 0) err = 1'b1;
    else err = 1'b0;
    rdata = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) mb[k][int'(o) + i] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = mb[k][int'(o) + i];
        if (ty == 3'd1 && v[15]) v[31:16] = 16'hFFFF;
        if (ty == 3'd3 && v[7])  v[31:8]  = 24'hFFFFFF;
        rdata = v;
      end
    end
  endtask

  task automatic commit(input int k);
    logic e;
    logic [31:0] r;
    predict(k, p_we[k], p_ty[k], p_ad[k], p_wd[k], e, r);
    m_err[k]   = e;
    m_rdata[k] = r;
    m_valid[k] = 1'b1;
    m_resp[k]  = 1'b1;
    rsp_cnt[k]++;
  endtask

  // Timing: accept in an idle cycle, commit wait_of(k) edges later (the accept
  // edge itself when zero), idle again one edge after the commit.
  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (!rst_d[k]) begin
        m_valid[k] = 1'b0;
        if (!m_busy[k]) begin
          if (rv[k]) begin
            p_we[k] = we_d[k];
            p_ty[k] = ty_d[k];
            p_ad[k] = ad_d[k];
            p_wd[k] = wd_d[k];
            m_busy[k]  = 1'b1;
            m_ready[k] = 1'b0;
            acc_cnt[k]++;
            m_left[k] = wait_of(k);
            if (m_left[k] == 0) commit(k);
          end
        end else if (m_resp[k]) begin
          m_busy[k]  = 1'b0;
          m_resp[k]  = 1'b0;
          m_ready[k] = 1'b1;
        end else begin
          m_left[k]--;
          if (m_left[k] == 0) commit(k);
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s inst%0d got=%h want=%h t=%0t", nm, k, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      chk("req_ready", k, 32'(dut_rdy[k]), 32'(m_ready[k]));
      chk("rsp_valid", k, 32'(dut_vld[k]), 32'(m_valid[k]));
      chk("rsp_err",   k, 32'(dut_err[k]), 32'(m_err[k]));
      chk("rsp_rdata", k, dut_rd[k], m_rdata[k]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input int k, input logic we, input logic [2:0] ty,
                        input logic [31:0] ad, input logic [31:0] wd, input bit hold);
    int n;
    int t;
    n = acc_cnt[k];
    rv[k]   = 1'b1;
    we_d[k] = we;
    ty_d[k] = ty;
    ad_d[k] = ad;
    wd_d[k] = wd;
    t = 0;
    while (acc_cnt[k] == n && t < 60) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (acc_cnt[k] == n) begin
      errors++;
      $display("FAIL accept_timeout inst%0d addr=%h waited=%0d cycles", k, ad, t);
    end
    if (!hold) rv[k] = 1'b0;
  endtask

  task automatic req_check(input string nm, input int k, input logic we,
                           input logic [2:0] ty, input logic [31:0] ad,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input logic exp_err, output int lat);
    int r;
    int c0;
    int t;
    r = rsp_cnt[k];
    do_req(k, we, ty, ad, wd, 1'b0);
    c0 = cyc;
    t = 0;
    while (rsp_cnt[k] == r && t < 60) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (rsp_cnt[k] == r) begin
      errors++;
      $display("FAIL rsp_timeout %s inst%0d waited=%0d cycles", nm, k, t);
    end
    lat = cyc - c0;
    chk({nm, "_dut"},   k, dut_rd[k], exp_rd);
    chk({nm, "_model"}, k, m_rdata[k], exp_rd);
    chk({nm, "_err"},   k, 32'(dut_err[k]), 32'(exp_err));
  endtask

  task automatic do_reset(input int k);
    rv[k] = 1'b0;
    #2;
    rst_d[k] = 1'b1;
    model_reset(k);
    #1;
    chk("rst_ready", k, 32'(dut_rdy[k]), 32'd1);
    chk("rst_valid", k, 32'(dut_vld[k]), 32'd0);
    chk("rst_rdata", k, dut_rd[k], 32'd0);
    chk("rst_err",   k, 32'(dut_err[k]), 32'd0);
    @(negedge clk);
    #2;
    rst_d[k] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    rst_d = '1;
    rv    = '0;
    we_d  = '0;
    ty_d  = '0;
    ad_d  = '0;
    wd_d  = '0;
    for (int k = 0; k < NI; k++) model_reset(k);
    repeat (3) @(negedge clk);
    #2;
    rst_d = '0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk("init_ready", k, 32'(dut_rdy[k]), 32'd1);

    // instance 0: base 0, 64 words, one wait state
    req_check("sw10", 0, 1'b1, 3'd0, 32'h10, 32'h12345678, 32'h0, 1'b0, lat);
    chk("sw_latency", 0, 32'(lat), 32'd1);
    req_check("lw10", 0, 1'b0, 3'd0, 32'h10, 32'h0, 32'h12345678, 1'b0, lat);
    chk("lw_latency", 0, 32'(lat), 32'd1);
    req_check("sb11",  0, 1'b1, 3'd3, 32'h11, 32'h000000AB, 32'h0, 1'b0, lat);
    req_check("lb11",  0, 1'b0, 3'd3, 32'h11, 32'h0, 32'hFFFFFFAB, 1'b0, lat);
    req_check("lbu11", 0, 1'b0, 3'd4, 32'h11, 32'h0, 32'h000000AB, 1'b0, lat);
    req_check("lw10b", 0, 1'b0, 3'd0, 32'h10, 32'h0, 32'h1234AB78, 1'b0, lat);
    req_check("sh22",  0, 1'b1, 3'd1, 32'h22, 32'h00008001, 32'h0, 1'b0, lat);
    req_check("lh22",  0, 1'b0, 3'd1, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, lat);
    req_check("lhu22", 0, 1'b0, 3'd2, 32'h22, 32'h0, 32'h00008001, 1'b0, lat);
    req_check("lw13",  0, 1'b0, 3'd0, 32'h13, 32'h0, 32'h0, 1'b1, lat);
    req_check("sh21",  0, 1'b1, 3'd1, 32'h21, 32'h0000FFFF, 32'h0, 1'b1, lat);
    req_check("type5", 0, 1'b1, 3'd5, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, lat);
    req_check("lw100", 0, 1'b0, 3'd0, 32'h100, 32'h0, 32'h0, 1'b1, lat);
    req_check("sw100", 0, 1'b1, 3'd0, 32'h100, 32'hCAFEF00D, 32'h0, 1'b1, lat);
    req_check("lw10c", 0, 1'b0, 3'd0, 32'h10, 32'h0, 32'h1234AB78, 1'b0, lat);
    req_check("lw20",  0, 1'b0, 3'd0, 32'h20, 32'h0, 32'h80010000, 1'b0, lat);
    // reset while the store is in WAIT: it must never reach memory
    do_req(0, 1'b1, 3'd0, 32'h40, 32'hDEADBEEF, 1'b0);
    do_reset(0);
    req_check("lw40rst", 0, 1'b0, 3'd0, 32'h40, 32'h0, 32'h0, 1'b0, lat);
    req_check("lw10rst", 0, 1'b0, 3'd0, 32'h10, 32'h0, 32'h0, 1'b0, lat);

    // instance 1: base 0x100, 32 words, no wait states, back-to-back burst
    do_req(1, 1'b1, 3'd0, 32'h104, 32'h11223344, 1'b1);
    do_req(1, 1'b0, 3'd0, 32'h104, 32'h0, 1'b1);
    do_req(1, 1'b0, 3'd1, 32'h106, 32'h0, 1'b1);
    do_req(1, 1'b0, 3'd3, 32'h107, 32'h0, 1'b1);
    do_req(1, 1'b1, 3'd0, 32'hFC, 32'h55555555, 1'b1);
    do_req(1, 1'b0, 3'd0, 32'h180, 32'h0, 1'b1);
    do_req(1, 1'b0, 3'd0, 32'h17C, 32'h0, 1'b0);
    repeat (4) @(negedge clk);
    req_check("b1_lw104",  1, 1'b0, 3'd0, 32'h104, 32'h0, 32'h11223344, 1'b0, lat);
    chk("b1_latency", 1, 32'(lat), 32'd0);
    req_check("b1_lbu104", 1, 1'b0, 3'd4, 32'h104, 32'h0, 32'h00000044, 1'b0, lat);
    req_check("b1_lwFC",   1, 1'b0, 3'd0, 32'hFC, 32'h0, 32'h0, 1'b1, lat);

    // instance 2: base 0x40, 16 words, three wait states
    req_check("b2_sh42", 2, 1'b1, 3'd2, 32'h42, 32'h0000BEEF, 32'h0, 1'b0, lat);
    chk("b2_latency", 2, 32'(lat), 32'd3);
    req_check("b2_lh42", 2, 1'b0, 3'd1, 32'h42, 32'h0, 32'hFFFFBEEF, 1'b0, lat);
    req_check("b2_lw40", 2, 1'b0, 3'd0, 32'h40, 32'h0, 32'hBEEF0000, 1'b0, lat);
    req_check("b2_lw3C", 2, 1'b0, 3'd0, 32'h3C, 32'h0, 32'h0, 1'b1, lat);

    // randomized traffic, checked every cycle against the model
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 250; n++) begin
        logic [2:0]  ty;
        logic [31:0] off;
        logic [31:0] ad;
        bit          hold;
        int          sz;
        ty  = ($urandom_range(0, 15) < 14) ? 3'($urandom_range(0, 4))
                                           : 3'($urandom_range(5, 7));
        sz  = (ty == 3'd0) ? 4 : (ty <= 3'd2) ? 2 : 1;
        off = 32'($urandom_range(0, 4 * words_of(k) + 7));
        if ($urandom_range(0, 7) != 0) off = off & ~32'(sz - 1);
        ad  = ($urandom_range(0, 15) == 0) ? base_of(k) - 32'd4 : base_of(k) + off;
        hold = bit'($urandom_range(0, 1));
        do_req(k, 1'($urandom_range(0, 1)), ty, ad, $urandom, hold);
        if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      rv[k] = 1'b0;
      repeat (8) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
